// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and state type for the data-memory arbiter slice.
// The top selects fixed priority instead of round robin when DATA_MEM_ARB_FIXED_PRIO_EN is defined.
package mips32_mem_pkg;

  localparam int unsigned DMEM_ADDR_W = 11;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter_arb.sv
// Two-requester combinational arbiter producing a one-hot grant.
// DATA_MEM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie; otherwise the non-last winner wins.
module rr_arbiter2
  import mips32_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt = '0;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
`else
  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // tie: the master that did not win last time goes next
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter and access sequencer for the single-port 2048x32 data memory.
// Tie-break mode is chosen by DATA_MEM_ARB_FIXED_PRIO_EN (default: round robin).
module data_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic [1:0] req;
  logic [1:0] gnt;

  assign req = {m1_req, m0_req};

  rr_arbiter2 u_arb (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = mem_write_q;
    mem_read_d  = mem_read_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d    = gnt[1];
          last_gnt_d = gnt[1];
          // the memory-side registers double as the request latch
          if (gnt[1]) begin
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
            mem_write_d = m1_we;
            mem_read_d  = ~m1_we;
          end else begin
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
            mem_write_d = m0_we;
            mem_read_d  = ~m0_we;
          end
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_read_q) begin
          if (owner_q) begin
            m1_rdata_d = mem_rdata;
          end else begin
            m0_rdata_d = mem_rdata;
          end
        end
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        m0_ack_d    = ~owner_q;
        m1_ack_d    = owner_q;
        state_d     = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural 2048x32 memory, directed steps, then random traffic
// checked against a transaction-level model (pending requests, arbitration rule, reference memory).
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [10:0] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        m0_ack, m1_ack, mem_write, mem_read;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // memory: async read, sync write
  logic [31:0] mem [0:2047];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read ? mem[mem_addr] : 'z;

  // reference model state
  logic [31:0] ref_mem [0:2047];
  logic [31:0] exp_rd [2];
  int          last_w;
  bit          pend [2];
  bit          p_we [2];
  logic [10:0] p_addr [2];
  logic [31:0] p_wd [2];
  bit          b2b;
  bit          fixed_prio;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input bit on);
    if (m == 0) begin
      m0_req = on; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wd[0];
    end else begin
      m1_req = on; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wd[1];
    end
  endtask

  task automatic present(input int m, input bit we, input logic [10:0] a, input logic [31:0] d);
    p_we[m] = we; p_addr[m] = a; p_wd[m] = d; pend[m] = 1'b1;
    drive(m, 1'b1);
  endtask

  function automatic int predict();
    if (pend[0] && pend[1]) return fixed_prio ? 0 : 1 - last_w;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    b2b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive(0, 1'b0); drive(1, 1'b0);
    last_w = 1; exp_rd[0] = '0; exp_rd[1] = '0; b2b = 1'b0;
    #1;
    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Waits for the next ack and checks it against the model's prediction.
  task automatic serve(input string tag, input bit keep, input bit perturb);
    int w, cyc, wcnt, rcnt, exp_lat;
    bit got;
    logic [10:0] acc_addr;
    logic [31:0] acc_wd;
    w = predict();
    exp_lat = b2b ? 3 : 2;
    cyc = 0; wcnt = 0; rcnt = 0; got = 1'b0;
    acc_addr = '0; acc_wd = '0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      chk({tag, "/excl"}, 32'(mem_write & mem_read), 32'd0);
      if (mem_write || mem_read) begin
        if (mem_write) wcnt++;
        if (mem_read) rcnt++;
        acc_addr = mem_addr; acc_wd = mem_wdata;
        if (perturb) begin
          if (w == 0) begin m0_addr = ~p_addr[0]; m0_wdata = ~p_wd[0]; end
          else begin m1_addr = ~p_addr[1]; m1_wdata = ~p_wd[1]; end
        end
      end
      got = m0_ack | m1_ack;
    end
    chk({tag, "/lat"}, 32'(cyc), 32'(exp_lat));
    if (got) begin
      chk({tag, "/who"}, 32'({m1_ack, m0_ack}), (w == 1) ? 32'd2 : 32'd1);
      chk({tag, "/wr_cyc"}, 32'(wcnt), p_we[w] ? 32'd1 : 32'd0);
      chk({tag, "/rd_cyc"}, 32'(rcnt), p_we[w] ? 32'd0 : 32'd1);
      chk({tag, "/addr"}, 32'(acc_addr), 32'(p_addr[w]));
      if (p_we[w]) begin
        chk({tag, "/wdata"}, acc_wd, p_wd[w]);
        ref_mem[p_addr[w]] = p_wd[w];
        chk({tag, "/commit"}, mem[p_addr[w]], ref_mem[p_addr[w]]);
      end else begin
        exp_rd[w] = ref_mem[p_addr[w]];
      end
      chk({tag, "/m0_rdata"}, m0_rdata, exp_rd[0]);
      chk({tag, "/m1_rdata"}, m1_rdata, exp_rd[1]);
      last_w = w;
    end
    b2b = 1'b1;
    if (keep) drive(w, 1'b1);
    else begin pend[w] = 1'b0; drive(w, 1'b0); end
  endtask

  task automatic rnd_present(input int m);
    logic [10:0] a;
    case ($urandom % 6)
      0: a = 11'h000;
      1: a = 11'h7FF;
      2: a = 11'h005;
      3: a = 11'h400;
      default: a = 11'($urandom);
    endcase
    present(m, 1'($urandom), a, $urandom);
  endtask

  initial begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B1 + 32'd7;
      ref_mem[i] = 32'(i) * 32'h9E3779B1 + 32'd7;
    end
    for (int m = 0; m < 2; m++) begin
      p_we[m] = 1'b0; p_addr[m] = '0; p_wd[m] = '0;
    end
    @(posedge clk); #1;
    do_reset();

    // 1: single write
    present(0, 1'b1, 11'h005, 32'hDEADBEEF);
    serve("t1", 1'b0, 1'b0);
    chk("t1_mem5", mem[5], 32'hDEADBEEF);

    // 2: other master reads it back
    present(1, 1'b0, 11'h005, 32'h0);
    serve("t2", 1'b0, 1'b0);
    chk("t2_m1_rdata", m1_rdata, 32'hDEADBEEF);

    // 3: simultaneous requests after reset, both held
    do_reset();
    present(0, 1'b0, 11'h100, 32'h0);
    present(1, 1'b0, 11'h200, 32'h0);
    serve("t3a", 1'b1, 1'b0);
    chk("t3a_first", 32'(last_w), 32'd0);
    serve("t3b", 1'b1, 1'b0);
    chk("t3b_second", 32'(last_w), fixed_prio ? 32'd0 : 32'd1);
    serve("t3c", 1'b1, 1'b0);
    serve("t3d", 1'b1, 1'b0);
    pend[0] = 1'b0; drive(0, 1'b0);
    serve("t3e", 1'b0, 1'b0);
    chk("t3e_m1", 32'(last_w), 32'd1);

    // 4: reset in the middle of a write access
    idle(2);
    present(1, 1'b1, 11'h7FF, 32'h12345678);
    @(posedge clk); #1;
    chk("t4_access", 32'(mem_write), 32'd1);
    #3;
    do_reset();
    chk("t4_mem7ff", mem[11'h7FF], ref_mem[11'h7FF]);
    present(0, 1'b0, 11'h7FF, 32'h0);
    serve("t4_after", 1'b0, 1'b0);

    // 5: address extremes
    idle(1);
    present(0, 1'b1, 11'h7FF, 32'h00000001);
    serve("t5w", 1'b0, 1'b0);
    present(0, 1'b0, 11'h000, 32'h0);
    serve("t5r0", 1'b0, 1'b0);
    chk("t5_rd0", m0_rdata, 32'd7);
    present(0, 1'b0, 11'h7FF, 32'h0);
    serve("t5r7ff", 1'b0, 1'b0);
    chk("t5_rd7ff", m0_rdata, 32'h00000001);

    // 6: inputs change while the access is in flight
    present(0, 1'b1, 11'h010, 32'hCAFEF00D);
    serve("t6", 1'b0, 1'b1);
    chk("t6_mem010", mem[11'h010], 32'hCAFEF00D);
    chk("t6_mem7ef", mem[11'h7EF], ref_mem[11'h7EF]);

    // random traffic
    for (int t = 0; t < 150; t++) begin
      if (!pend[0] && !pend[1] && ($urandom % 4 == 0)) idle(1 + int'($urandom % 3));
      for (int m = 0; m < 2; m++) if (!pend[m] && ($urandom % 2 == 1)) rnd_present(m);
      if (!pend[0] && !pend[1]) rnd_present(int'($urandom % 2));
      serve("rnd", 1'b0, 1'b0);
    end
    while (pend[0] || pend[1]) serve("rnd_tail", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
